// File: rtl/pkt_read_hcp_pkg.sv
// Shared types and widths for the host-port packet read path.
package hcp_pkg;

  localparam int BUFID_W        = 9;
  localparam int LEN_W          = 11;
  localparam int WORD_IDX_W     = 8;
  localparam int MEM_DW         = 64;
  localparam int FIRST_BYTE_BIT = 8;
  localparam int ADDR_W         = BUFID_W + WORD_IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    GAP,
    ERR
  } state_t;

  // Index of the final 64-bit word of a packet; len must be non-zero.
  function automatic logic [WORD_IDX_W-1:0] last_word_idx(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] len_m1;
    len_m1 = len - LEN_W'(1);
    return len_m1[LEN_W-1:3];
  endfunction

endpackage

// File: rtl/pkt_read_hcp_if.sv
// Request, memory-read and byte-stream signals of the packet reader.
interface pkt_read_hcp_if
  import hcp_pkg::*;
();

  logic [BUFID_W-1:0]      iv_pkt_bufid;
  logic [LEN_W-1:0]        iv_pkt_len;
  logic                    i_pkt_bufid_wr;
  logic                    o_pkt_bufid_ready;
  logic [ADDR_W-1:0]       ov_pkt_raddr;
  logic                    o_pkt_rd;
  logic [MEM_DW-1:0]       iv_pkt_rdata;
  logic [FIRST_BYTE_BIT:0] ov_pkt_data;
  logic                    o_pkt_data_wr;
  logic [BUFID_W-1:0]      ov_free_bufid;
  logic                    o_free_bufid_wr;
  logic                    o_len_err;
  logic [31:0]             ov_tx_pkt_cnt;
  logic [15:0]             ov_len_err_cnt;

  modport master (
    output iv_pkt_bufid, iv_pkt_len, i_pkt_bufid_wr, iv_pkt_rdata,
    input  o_pkt_bufid_ready, ov_pkt_raddr, o_pkt_rd, ov_pkt_data, o_pkt_data_wr,
    input  ov_free_bufid, o_free_bufid_wr, o_len_err, ov_tx_pkt_cnt, ov_len_err_cnt
  );

  modport slave (
    input  iv_pkt_bufid, iv_pkt_len, i_pkt_bufid_wr, iv_pkt_rdata,
    output o_pkt_bufid_ready, ov_pkt_raddr, o_pkt_rd, ov_pkt_data, o_pkt_data_wr,
    output ov_free_bufid, o_free_bufid_wr, o_len_err, ov_tx_pkt_cnt, ov_len_err_cnt
  );

endinterface

// File: rtl/pkt_word_serializer_hcp.sv
// Two-entry word buffer feeding a byte selector; an arriving word bypasses the
// buffer when it is empty, so the first byte leaves one cycle after the word lands.
module pkt_word_serializer_hcp
  import hcp_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic                    word_vld,
  input  logic [MEM_DW-1:0]       word_dat,
  output logic [1:0]              fill,
  output logic [FIRST_BYTE_BIT:0] byte_dat,
  output logic                    byte_vld,
  output logic                    byte_last
);

  logic [MEM_DW-1:0] words [2];
  logic              head;
  logic [2:0]        sel;
  logic [LEN_W-1:0]  left;
  logic              first;

  logic [MEM_DW-1:0] cur_word;
  logic [MEM_DW-1:0] shifted;
  logic              have_word;
  logic              emit;
  logic              word_done;
  logic              push;
  logic              pop;
  logic              wr_ptr;

  always_comb begin
    have_word = (fill != 2'd0) || word_vld;
    cur_word  = (fill != 2'd0) ? words[head] : word_dat;
    shifted   = cur_word << {sel, 3'b000};
    emit      = (left != '0) && have_word;
    word_done = emit && ((sel == 3'd7) || (left == LEN_W'(1)));
    // A word fully consumed straight off the bypass never occupies an entry.
    push      = word_vld && !((fill == 2'd0) && word_done);
    pop       = word_done && (fill != 2'd0);
    wr_ptr    = head ^ fill[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill      <= 2'd0;
      head      <= 1'b0;
      sel       <= 3'd0;
      left      <= '0;
      first     <= 1'b0;
      byte_dat  <= '0;
      byte_vld  <= 1'b0;
      byte_last <= 1'b0;
      words[0]  <= '0;
      words[1]  <= '0;
    end else begin
      byte_vld  <= emit;
      byte_last <= emit && (left == LEN_W'(1));
      byte_dat  <= emit ? {first, shifted[MEM_DW-1 -: 8]} : '0;
      if (start) begin
        left  <= len;
        sel   <= 3'd0;
        first <= 1'b1;
        fill  <= 2'd0;
        head  <= 1'b0;
      end else begin
        if (emit) begin
          left  <= left - LEN_W'(1);
          first <= 1'b0;
          sel   <= word_done ? 3'd0 : sel + 3'd1;
        end
        if (push) words[wr_ptr] <= word_dat;
        if (pop) head <= ~head;
        fill <= fill + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: rtl/pkt_read_hcp.sv
// Packet buffer reader: one 64-bit read stream per bufid, serialized to 9-bit bytes
// with a forced inter-packet gap. Statistics counters exist only with PKT_READ_STAT_EN.
module pkt_read_hcp
  import hcp_pkg::*;
#(
  parameter int MEM_RD_LAT = 2,
  parameter int IFG_CYCLES = 12
) (
  input  logic           i_clk,
  input  logic           i_rst,
  pkt_read_hcp_if.slave  bus
);

  state_t                  state;
  logic [BUFID_W-1:0]      bufid;
  logic [WORD_IDX_W-1:0]   word_idx;
  logic [WORD_IDX_W-1:0]   words_left;
  logic                    outstanding;
  logic [MEM_RD_LAT-1:0]   rd_pipe;
  logic [7:0]              gap_cnt;
  logic                    ready;
  logic                    rd;
  logic [ADDR_W-1:0]       raddr;
  logic                    free_wr;
  logic [BUFID_W-1:0]      free_bufid;
  logic                    len_err;

  logic                    accept;
  logic                    len_zero;
  logic                    issue;
  logic                    rd_vld;
  logic                    ser_start;
  logic [1:0]              fill;
  logic [FIRST_BYTE_BIT:0] byte_dat;
  logic                    byte_vld;
  logic                    byte_last;

  assign accept    = bus.i_pkt_bufid_wr && ready;
  assign len_zero  = (bus.iv_pkt_len == '0);
  assign ser_start = accept && !len_zero;
  assign rd_vld    = rd_pipe[MEM_RD_LAT-1];
  // One read in flight and a free entry guarantee the arriving word has a slot.
  assign issue     = (state == READ) && (words_left != '0) && !outstanding && (fill != 2'd2);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      bufid       <= '0;
      word_idx    <= '0;
      words_left  <= '0;
      outstanding <= 1'b0;
      rd_pipe     <= '0;
      gap_cnt     <= '0;
      ready       <= 1'b0;
      rd          <= 1'b0;
      raddr       <= '0;
      free_wr     <= 1'b0;
      free_bufid  <= '0;
      len_err     <= 1'b0;
    end else begin
      rd      <= 1'b0;
      free_wr <= 1'b0;
      len_err <= 1'b0;
      rd_pipe <= (rd_pipe << 1) | MEM_RD_LAT'(rd);
      if (rd_vld) outstanding <= 1'b0;
      case (state)
        IDLE: begin
          ready <= 1'b1;
          if (accept) begin
            ready <= 1'b0;
            bufid <= bus.iv_pkt_bufid;
            if (len_zero) begin
              state      <= ERR;
              len_err    <= 1'b1;
              free_wr    <= 1'b1;
              free_bufid <= bus.iv_pkt_bufid;
            end else begin
              state       <= READ;
              rd          <= 1'b1;
              raddr       <= {bus.iv_pkt_bufid, WORD_IDX_W'(0)};
              word_idx    <= WORD_IDX_W'(1);
              words_left  <= last_word_idx(bus.iv_pkt_len);
              outstanding <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            rd          <= 1'b1;
            raddr       <= {bufid, word_idx};
            word_idx    <= word_idx + WORD_IDX_W'(1);
            words_left  <= words_left - WORD_IDX_W'(1);
            outstanding <= 1'b1;
          end
          if (byte_last) begin
            state      <= GAP;
            free_wr    <= 1'b1;
            free_bufid <= bufid;
            gap_cnt    <= 8'(IFG_CYCLES - 1);
          end
        end
        GAP: begin
          if (gap_cnt == 8'd0) begin
            state <= IDLE;
            ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        ERR: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  pkt_word_serializer_hcp u_ser (
    .clk       (i_clk),
    .rst       (i_rst),
    .start     (ser_start),
    .len       (bus.iv_pkt_len),
    .word_vld  (rd_vld),
    .word_dat  (bus.iv_pkt_rdata),
    .fill      (fill),
    .byte_dat  (byte_dat),
    .byte_vld  (byte_vld),
    .byte_last (byte_last)
  );

  assign bus.o_pkt_bufid_ready = ready;
  assign bus.ov_pkt_raddr      = raddr;
  assign bus.o_pkt_rd          = rd;
  assign bus.ov_pkt_data       = byte_dat;
  assign bus.o_pkt_data_wr     = byte_vld;
  assign bus.ov_free_bufid     = free_bufid;
  assign bus.o_free_bufid_wr   = free_wr;
  assign bus.o_len_err         = len_err;

`ifdef PKT_READ_STAT_EN
  logic [31:0] tx_cnt;
  logic [15:0] err_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (free_wr && !len_err && (tx_cnt != '1)) tx_cnt <= tx_cnt + 32'd1;
      if (len_err && (err_cnt != '1)) err_cnt <= err_cnt + 16'd1;
    end
  end

  assign bus.ov_tx_pkt_cnt  = tx_cnt;
  assign bus.ov_len_err_cnt = err_cnt;
`else
  assign bus.ov_tx_pkt_cnt  = '0;
  assign bus.ov_len_err_cnt = '0;
`endif

endmodule
